mem_cmd_responder: RTL and testbench

Memory-side command responder for the RISC core's external memory interface. It decodes the 3-bit `cmd` code issued by the core (ReadA, WriteA, Refresh, Precharge, and the three register loads), serves reads and writes from an internal word array with byte masking, and returns `cmdack` after a programmable latency. It also keeps the mode, timing and refresh-counter registers, and raises `refresh_due` when a refresh interval expires.

---
 rtl/mem_cmd_responder_if.sv | 27 ++
 rtl/mem_cmd_responder.sv | 150 +++++++++++++++
 tb/tb_mem_cmd_responder.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/mem_cmd_responder_if.sv
// Command/data bundle between the core's memory port and the responder.
// The core is the master; the responder is the slave.
interface mem_cmd_responder_if #(
    parameter int data_size = 32,
    parameter int padd_size = 24,
    parameter int cmd_size  = 3,
    parameter int dqm_size  = 4
);
    logic [cmd_size-1:0]  cmd;
    logic [padd_size-1:0] paddr;
    logic [dqm_size-1:0]  dm;
    logic [data_size-1:0] mem_dataout;
    logic [data_size-1:0] mem_datain;
    logic                 cmdack;
    logic                 busy;
    logic                 refresh_due;

    modport master (
        output cmd, paddr, dm, mem_dataout,
        input  mem_datain, cmdack, busy, refresh_due
    );

    modport slave (
        input  cmd, paddr, dm, mem_dataout,
        output mem_datain, cmdack, busy, refresh_due
    );
endinterface

// File: rtl/mem_cmd_responder.sv
// Memory-side command responder: byte-masked word array, mode/timing
// registers, programmable ack latency and a free-running refresh timer.
module mem_cmd_responder #(
    parameter int data_size      = 32,
    parameter int dqm_size       = 4,
    parameter int mem_depth_log2 = 8
) (
    input logic                clk0,
    input logic                reset,
    mem_cmd_responder_if.slave bus
);
    typedef enum logic {IDLE, EXEC} state_e;
    typedef enum logic [1:0] {OP_OTHER, OP_READ, OP_REFRESH} op_e;

    localparam int depth = 1 << mem_depth_log2;

    state_e                    state_q, state_d;
    op_e                       op_q, op_d;
    logic [3:0]                lat_q, lat_d, lat_new;
    logic [mem_depth_log2-1:0] addr_q, addr_d;
    logic [7:0]                mode_q, mode_d;
    logic [7:0]                timing_q, timing_d;
    logic [15:0]               reload_q, reload_d;
    logic [15:0]               ref_cnt_q, ref_cnt_d;
    logic                      due_q, due_d;
    logic                      ack_q, ack_d;
    logic                      busy_q, busy_d;
    logic [data_size-1:0]      dout_q, dout_d;
    logic [data_size-1:0]      mem_q [depth];
    logic                      wr_en, ref_load, ref_set, ref_clr;

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        lat_d     = lat_q;
        lat_new   = 4'd1;
        addr_d    = addr_q;
        mode_d    = mode_q;
        timing_d  = timing_q;
        reload_d  = reload_q;
        ref_cnt_d = ref_cnt_q;
        due_d     = due_q;
        ack_d     = 1'b0;
        dout_d    = mode_q[0] ? dout_q : '0;
        wr_en     = 1'b0;
        ref_load  = 1'b0;
        ref_set   = 1'b0;
        ref_clr   = 1'b0;

        case (state_q)
            IDLE: begin
                op_d = OP_OTHER;
                case (bus.cmd)
                    3'b001: begin
                        op_d    = OP_READ;
                        addr_d  = bus.paddr[mem_depth_log2-1:0];
                        lat_new = {1'b0, timing_q[2:0]};
                    end
                    3'b010: wr_en = 1'b1;
                    3'b011: begin
                        op_d    = OP_REFRESH;
                        lat_new = timing_q[6:3];
                    end
                    3'b101: mode_d = bus.paddr[7:0];
                    3'b110: timing_d = bus.paddr[7:0];
                    3'b111: begin
                        reload_d = bus.paddr[15:0];
                        ref_load = 1'b1;
                    end
                    default: ;
                endcase
                // NOP and Precharge leave the responder idle
                if (bus.cmd != 3'b000 && bus.cmd != 3'b100) begin
                    state_d = EXEC;
                    lat_d   = (lat_new == 4'd0) ? 4'd1 : lat_new;
                end
            end
            EXEC: begin
                if (lat_q <= 4'd1) begin
                    state_d = IDLE;
                    ack_d   = 1'b1;
                    ref_clr = (op_q == OP_REFRESH);
                    if (op_q == OP_READ) dout_d = mem_q[addr_q];
                end else begin
                    lat_d = lat_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (ref_cnt_q == 16'd0) begin
            ref_cnt_d = reload_q;
            ref_set   = 1'b1;
        end else begin
            ref_cnt_d = ref_cnt_q - 16'd1;
        end
        if (ref_load) ref_cnt_d = bus.paddr[15:0];

        // an expiry on the same edge as a Refresh completion keeps the flag
        if (ref_set) due_d = 1'b1;
        else if (ref_clr) due_d = 1'b0;

        busy_d = (state_d == EXEC);
    end

    always_ff @(posedge clk0) begin
        if (reset) begin
            state_q   <= IDLE;
            op_q      <= OP_OTHER;
            lat_q     <= 4'd0;
            addr_q    <= '0;
            mode_q    <= 8'h00;
            timing_q  <= 8'h22;
            reload_q  <= 16'h0618;
            ref_cnt_q <= 16'h0618;
            due_q     <= 1'b0;
            ack_q     <= 1'b0;
            busy_q    <= 1'b0;
            dout_q    <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            lat_q     <= lat_d;
            addr_q    <= addr_d;
            mode_q    <= mode_d;
            timing_q  <= timing_d;
            reload_q  <= reload_d;
            ref_cnt_q <= ref_cnt_d;
            due_q     <= due_d;
            ack_q     <= ack_d;
            busy_q    <= busy_d;
            dout_q    <= dout_d;
        end
    end

    // array is deliberately left out of reset
    always_ff @(posedge clk0) begin
        if (wr_en && !reset) begin
            for (int i = 0; i < dqm_size; i++) begin
                if (!bus.dm[i])
                    mem_q[bus.paddr[mem_depth_log2-1:0]][8*i +: 8] <= bus.mem_dataout[8*i +: 8];
            end
        end
    end

    assign bus.cmdack      = ack_q;
    assign bus.busy        = busy_q;
    assign bus.refresh_due = due_q;
    assign bus.mem_datain  = dout_q;
endmodule

// File: tb/tb_mem_cmd_responder.sv
// Randomized bench for mem_cmd_responder against a transaction-level
// model (ack deadlines, word array, register file, refresh timer).
module tb_mem_cmd_responder;
    logic clk0 = 1'b0;
    logic reset = 1'b1;
    always #5 clk0 = ~clk0;

    mem_cmd_responder_if bus ();

    mem_cmd_responder dut (
        .clk0  (clk0),
        .reset (reset),
        .bus   (bus.slave)
    );

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;

    logic [31:0] m_mem [256];
    logic [7:0]  m_mode, m_timing;
    int          m_reload, m_refcnt;
    bit          m_busy;
    int          m_ack_at, m_op, m_addr;
    bit          e_ack, e_busy, e_due;
    logic [31:0] e_dout;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h want %h (edge %0d)", tag, got, exp, cyc);
    endtask

    task automatic model_step();
        int c, lat;
        bit clr, set, ld;
        c = int'(bus.cmd);
        clr = 0; set = 0; ld = 0;
        cyc++;
        if (reset) begin
            m_mode = 8'h00; m_timing = 8'h22;
            m_reload = 'h618; m_refcnt = 'h618;
            m_busy = 0; e_ack = 0; e_busy = 0; e_due = 0; e_dout = '0;
            return;
        end
        e_ack = 0;
        if (!m_mode[0]) e_dout = '0;
        if (m_busy) begin
            if (cyc == m_ack_at) begin
                m_busy = 0; e_ack = 1;
                if (m_op == 1) e_dout = m_mem[m_addr];
                if (m_op == 3) clr = 1;
            end
        end else if (c != 0 && c != 4) begin
            if (c == 1) lat = int'(m_timing[2:0]);
            else if (c == 3) lat = int'(m_timing[6:3]);
            else lat = 1;
            if (lat == 0) lat = 1;
            m_busy = 1; m_ack_at = cyc + lat; m_op = c;
            m_addr = int'(bus.paddr[7:0]);
            case (c)
                2: for (int i = 0; i < 4; i++)
                    if (!bus.dm[i]) m_mem[m_addr][8*i +: 8] = bus.mem_dataout[8*i +: 8];
                5: m_mode = bus.paddr[7:0];
                6: m_timing = bus.paddr[7:0];
                7: begin m_reload = int'(bus.paddr[15:0]); ld = 1; end
                default: ;
            endcase
        end
        if (m_refcnt == 0) begin m_refcnt = m_reload; set = 1; end
        else m_refcnt--;
        if (ld) m_refcnt = int'(bus.paddr[15:0]);
        if (set) e_due = 1;
        else if (clr) e_due = 0;
        e_busy = m_busy;
    endtask

    task automatic tick();
        @(posedge clk0);
        model_step();
        #1;
        chk("cmdack", bus.cmdack, e_ack);
        chk("busy", bus.busy, e_busy);
        chk("refresh_due", bus.refresh_due, e_due);
        chk("mem_datain", bus.mem_datain, e_dout);
    endtask

    task automatic drv(logic [2:0] c, logic [23:0] a, logic [3:0] m, logic [31:0] d);
        bus.cmd = c; bus.paddr = a; bus.dm = m; bus.mem_dataout = d;
    endtask

    task automatic issue(logic [2:0] c, logic [23:0] a, logic [3:0] m,
                         logic [31:0] d, output int lat, output logic [31:0] rd);
        drv(c, a, m, d);
        tick();
        drv(3'd0, 24'd0, 4'd0, 32'd0);
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!bus.cmdack && lat < 40);
        if (lat >= 40) chk("ack_timeout", 32'd0, 32'd1);
        rd = bus.mem_datain;
    endtask

    initial begin
        int lat;
        logic [31:0] rd;
        logic [2:0] c;
        logic [23:0] a;
        drv(3'd0, 24'd0, 4'd0, 32'd0);
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;

        for (int i = 0; i < 32; i++) issue(3'd2, 24'(i), 4'd0, $urandom, lat, rd);

        issue(3'd2, 24'h000010, 4'd0, 32'hDEADBEEF, lat, rd);
        chk("wr_lat", lat, 1);
        issue(3'd1, 24'h000010, 4'd0, 32'd0, lat, rd);
        chk("rd_lat", lat, 2);
        chk("rd_data", rd, 32'hDEADBEEF);
        tick();
        chk("dout_clr", bus.mem_datain, 32'd0);

        issue(3'd6, 24'h000005, 4'd0, 32'd0, lat, rd);
        issue(3'd1, 24'h000010, 4'd0, 32'd0, lat, rd);
        chk("cl5_lat", lat, 5);
        issue(3'd3, 24'd0, 4'd0, 32'd0, lat, rd);
        chk("trfc0_lat", lat, 1);

        issue(3'd2, 24'h000010, 4'd0, 32'hFFFFFFFF, lat, rd);
        issue(3'd2, 24'h000010, 4'b1010, 32'h00000000, lat, rd);
        issue(3'd1, 24'h000110, 4'd0, 32'd0, lat, rd);
        chk("mask_alias", rd, 32'hFF00FF00);
        issue(3'd6, 24'h000022, 4'd0, 32'd0, lat, rd);

        issue(3'd7, 24'h000003, 4'd0, 32'd0, lat, rd);
        repeat (4) tick();
        chk("due_set", bus.refresh_due, 1);
        issue(3'd3, 24'd0, 4'd0, 32'd0, lat, rd);
        chk("trfc4_lat", lat, 4);
        chk("due_clr", bus.refresh_due, 0);
        issue(3'd7, 24'h000005, 4'd0, 32'd0, lat, rd);
        issue(3'd3, 24'd0, 4'd0, 32'd0, lat, rd);
        chk("due_set_wins", bus.refresh_due, 1);

        issue(3'd5, 24'h000001, 4'd0, 32'd0, lat, rd);
        issue(3'd2, 24'h000010, 4'd0, 32'hCAFEF00D, lat, rd);
        issue(3'd1, 24'h000010, 4'd0, 32'd0, lat, rd);
        tick();
        chk("dout_hold", bus.mem_datain, 32'hCAFEF00D);
        drv(3'd1, 24'h000010, 4'd0, 32'd0); tick();
        drv(3'd1, 24'h000011, 4'd0, 32'd0); tick();
        drv(3'd0, 24'd0, 4'd0, 32'd0); tick();
        chk("ign_ack", bus.cmdack, 1);
        tick();
        chk("ign_busy", bus.busy, 0);
        issue(3'd5, 24'h000000, 4'd0, 32'd0, lat, rd);

        issue(3'd6, 24'h000005, 4'd0, 32'd0, lat, rd);
        drv(3'd1, 24'h000010, 4'd0, 32'd0); tick();
        drv(3'd0, 24'd0, 4'd0, 32'd0); tick();
        reset = 1'b1; tick();
        reset = 1'b0;
        chk("rst_ack", bus.cmdack, 0);
        chk("rst_busy", bus.busy, 0);
        issue(3'd1, 24'h000010, 4'd0, 32'd0, lat, rd);
        chk("rst_cl", lat, 2);
        chk("rst_keep", rd, 32'hCAFEF00D);

        repeat (3000) begin
            reset = ($urandom_range(0, 199) == 0);
            c = $urandom_range(0, 1) ? 3'($urandom_range(1, 7)) : 3'd0;
            case (c)
                3'd7: a = 24'($urandom_range(0, 50));
                3'd5, 3'd6: a = 24'($urandom_range(0, 255));
                default: a = (24'($urandom) & 24'hFFFF00) | 24'($urandom_range(0, 31));
            endcase
            drv(c, a, 4'($urandom), $urandom);
            tick();
        end
        reset = 1'b0;
        drv(3'd0, 24'd0, 4'd0, 32'd0);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
